sram_burst_streamer: RTL and testbench
======================================

# sram_burst_streamer

Burst read controller sitting directly in front of the single-port, 1-cycle-latency SRAM macro in the MAC engine. It drives the macro's CEB/WEB/A/D pins and consumes its Q, converting a base/length command into a valid/ready word stream with full backpressure. A 2-entry output FIFO with credit-based issue keeps back-to-back throughput at 1 word/cycle.

## Interface
- numWord, 2048: SRAM depth, power of two; AW = $clog2(numWord)
- numBit, 32: word width
- LW, 12: burst length field width
- reset  in  1  asynchronous, active-low
- CLK  in  1  clock
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high in IDLE only
- cmd_addr  in  AW  base word address
- cmd_len  in  LW  burst length minus one (0 = 1 word)
- cmd_write  in  1  1 = write burst (only with STREAMER_WRITE_EN)
- out_valid / out_ready  out / in  1  read stream handshake
- out_data  out  numBit  read word
- out_last  out  1  high with final word of burst
- in_valid / in_ready / in_data  in / out / in  1/1/numBit  write stream (only with STREAMER_WRITE_EN)
- sram_CEB, sram_WEB  out  1  active-low chip/write enable
- sram_A  out  AW  address; sram_D  out  numBit  write data; sram_Q  in  numBit  read data
- busy  out  1  state != IDLE; done  out  1  one-cycle pulse at burst end

## Operation
- States: IDLE, READ, DRAIN, WRITE. Reset -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr, remaining=cmd_len; go READ (or WRITE if cmd_write).
- READ: issue = (fifo_count + inflight - pop) < 2, pop = out_valid&out_ready. On issue: sram_CEB=0, sram_WEB=1, sram_A=addr; addr+1, remaining-1. After issuing the last word -> DRAIN.
- inflight: 1-bit flag set the cycle after an issue edge; sram_Q pushed into FIFO at the following edge, tagged last if it was the final address.
- DRAIN: no issues; when final word popped -> done=1, IDLE.
- FIFO: 2 entries, head drives out_data/out_last, out_valid = count!=0. Never overflows by the credit rule.
- Address wraps modulo numWord (AW-bit counter, no error).
- sram_A holds last value when CEB=1; sram_D=0 in read mode.
- Reset asserted mid-burst: immediately IDLE, FIFO and inflight cleared, outputs to reset values; burst discarded.

## Timing
- Reset values: cmd_ready=1 (IDLE), sram_CEB=1, sram_WEB=1, sram_A=0, sram_D=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, in_ready=0.
- Command accepted at edge E0: first CEB=0 in cycle after E0; SRAM samples at E1; word enters FIFO at E2; out_valid=1 in cycle after E2 (2-cycle latency).
- out_ready held high: one word per cycle, no bubbles; N-word burst occupies N+2 cycles from acceptance to done.
- out_ready low: at most 2 words buffered, issue stops; resumes in the same cycle out_ready returns.
- done asserts in cycle following the last pop edge; cmd_ready high in that same cycle; next command may be accepted there.

## Configuration
- STREAMER_WRITE_EN defined: cmd_write and in_* ports exist; WRITE state: in_ready=1, each in_valid&in_ready drives sram_CEB=0, sram_WEB=0, sram_A=addr, sram_D=in_data combinationally; after last word, done pulse next cycle, back to IDLE. No output stream activity.
- Undefined: ports absent, WRITE unreachable, sram_WEB constant 1.

## Test plan
- Reset then cmd addr=0x010, len=3, out_ready=1 (SRAM preloaded addr=value) -> out_data 0x10..0x13 on consecutive cycles, out_last on 0x13, done 1 cycle later, first out_valid 2 cycles after accept.
- Same burst, out_ready toggled 1-0-0-1 -> no loss/duplication, never >2 buffered, CEB high while full.
- addr=numWord-2, len=3 -> sram_A sequence 2046,2047,0,1.
- len=0 -> single word with out_last=1, done pulse, cmd_ready returns.
- reset pulsed mid-burst (after 2 words) -> out_valid=0, CEB=1, IDLE; new burst completes correctly.
- STREAMER_WRITE_EN: write burst addr=0x20 len=1 data 0xA5,0x5A, then read back -> 0xA5,0x5A.

Source files
------------

// File: rtl/sram_burst_streamer.sv
// sram_burst_streamer: burst controller for a single-port 1-cycle-latency SRAM macro
// Converts a base/length command into a valid/ready read stream with full backpressure,
// using a 2-entry output FIFO and credit-based issue to sustain 1 word/cycle.
// Optional write bursts are compiled in when STREAMER_WRITE_EN is defined.
//
// Ports:
//   reset                      asynchronous active-low reset
//   CLK                        clock
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_addr, cmd_len          base word address, burst length minus one
//   cmd_write                  write burst select (STREAMER_WRITE_EN only)
//   in_valid/in_ready/in_data  write data stream (STREAMER_WRITE_EN only)
//   out_valid/out_ready        read stream handshake
//   out_data, out_last         read word, final-word marker
//   sram_CEB, sram_WEB         active-low chip / write enable
//   sram_A, sram_D, sram_Q     SRAM address, write data, read data
//   busy, done                 not-idle flag, one-cycle end-of-burst pulse
module sram_burst_streamer #(
    parameter int numWord = 2048,
    parameter int numBit  = 32,
    parameter int LW      = 12,
    localparam int AW     = $clog2(numWord)
) (
    input  logic              reset,
    input  logic              CLK,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LW-1:0]     cmd_len,
`ifdef STREAMER_WRITE_EN
    input  logic              cmd_write,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [numBit-1:0] in_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [numBit-1:0] out_data,
    output logic              out_last,
    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [AW-1:0]     sram_A,
    output logic [numBit-1:0] sram_D,
    input  logic [numBit-1:0] sram_Q,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;
    state_t state, state_nx;
    logic [AW-1:0]     addr, a_hold;
    logic [LW-1:0]     remaining;
    logic              inflight, inflight_last;
    logic [numBit-1:0] mem_d [2];
    logic              mem_l [2];
    logic              wp, rp;
    logic [1:0]        count;
    logic [2:0]        credit;
    logic              accept, pop, issue, last_pop, done_r;
    logic              go_write, wr;
    logic [numBit-1:0] wdata;
`ifdef STREAMER_WRITE_EN
    assign go_write = cmd_write;
    assign wr       = state == WRITE && in_valid;
    assign wdata    = in_data;
`else
    assign go_write = 1'b0;
    assign wr       = 1'b0;
    assign wdata    = '0;
`endif
    assign accept   = cmd_valid && state == IDLE;
    assign pop      = count != 2'd0 && out_ready;
    // Words already buffered plus the one in the SRAM pipe, net of this cycle's pop,
    // must leave room in the FIFO for the word being issued now.
    assign credit   = {1'b0, count} + 3'(inflight) - 3'(pop);
    assign issue    = state == READ && credit < 3'd2;
    assign last_pop = pop && mem_l[rp];

    always_ff @(posedge CLK or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = go_write ? WRITE : READ;
            READ:    if (issue && remaining == '0) state_nx = DRAIN;
            DRAIN:   if (last_pop) state_nx = IDLE;
            WRITE:   if (wr && remaining == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        out_valid = count != 2'd0;
        out_data  = mem_d[rp];
        out_last  = count != 2'd0 && mem_l[rp];
        sram_CEB  = !(issue || wr);
        sram_WEB  = !wr;
        sram_A    = (issue || wr) ? addr : a_hold;
        sram_D    = wr ? wdata : '0;
        done      = done_r;
`ifdef STREAMER_WRITE_EN
        in_ready  = state == WRITE;
`endif
    end

    always_ff @(posedge CLK or negedge reset)
        if (!reset) begin
            addr          <= '0;
            a_hold        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            mem_d[0]      <= '0;
            mem_d[1]      <= '0;
            mem_l[0]      <= 1'b0;
            mem_l[1]      <= 1'b0;
            wp            <= 1'b0;
            rp            <= 1'b0;
            count         <= 2'd0;
            done_r        <= 1'b0;
        end else begin
            if (accept) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue || wr) begin
                addr      <= addr + AW'(1);
                remaining <= remaining - LW'(1);
            end
            if (issue || wr) a_hold <= addr;
            // SRAM returns the word one cycle after the issue edge; capture it then.
            inflight <= issue;
            if (issue) inflight_last <= remaining == '0;
            if (inflight) begin
                mem_d[wp] <= sram_Q;
                mem_l[wp] <= inflight_last;
                wp        <= ~wp;
            end
            if (pop) rp <= ~rp;
            count  <= count + 2'(inflight) - 2'(pop);
            done_r <= (state == DRAIN && last_pop) || (wr && remaining == '0);
        end
endmodule

// File: tb/tb_sram_burst_streamer.sv
// tb_sram_burst_streamer: directed self-checking bench for sram_burst_streamer with an SRAM model
module tb_sram_burst_streamer;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_addr = '0;
    logic [11:0] cmd_len = '0;
`ifdef STREAMER_WRITE_EN
    logic        cmd_write = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        sram_CEB, sram_WEB;
    logic [10:0] sram_A;
    logic [31:0] sram_D;
    logic [31:0] sram_Q = '0;
    logic        busy, done;
    logic [31:0] mem [2048];
    int checks = 0;
    int failures = 0;

    sram_burst_streamer dut (
        .reset(reset), .CLK(CLK),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef STREAMER_WRITE_EN
        .cmd_write(cmd_write), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_A(sram_A), .sram_D(sram_D),
        .sram_Q(sram_Q), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        if (!sram_CEB) begin
            if (!sram_WEB) mem[sram_A] <= sram_D;
            else           sram_Q <= mem[sram_A];
        end

    task automatic issue_cmd(input logic [10:0] a, input logic [11:0] l);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if ({cmd_ready, sram_CEB, sram_WEB, busy, done, out_valid, out_last} !== 7'b1110000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 1110000", {cmd_ready, sram_CEB, sram_WEB, busy, done, out_valid, out_last});
        end
        checks++;
        if ({sram_A, sram_D, out_data} !== 75'd0) begin
            failures++;
            $display("FAIL reset_buses A=%h D=%h data=%h exp 0", sram_A, sram_D, out_data);
        end
        @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        issue_cmd(11'h010, 12'd3);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            checks++;
            if (sram_CEB !== !(k <= 4) || sram_A !== 11'(k <= 4 ? 'h10 + k - 1 : 'h13)) begin
                failures++;
                $display("FAIL basic_sram k=%0d CEB=%b A=%h", k, sram_CEB, sram_A);
            end
            checks++;
            if ({out_valid, out_last, done, cmd_ready} !== {k >= 3 && k <= 6, k == 6, k == 7, k >= 7}) begin
                failures++;
                $display("FAIL basic_flags k=%0d got %b exp %b", k, {out_valid, out_last, done, cmd_ready},
                         {k >= 3 && k <= 6, k == 6, k == 7, k >= 7});
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (out_data !== 32'h10 + 32'(k - 3)) begin
                    failures++;
                    $display("FAIL basic_data k=%0d got %h exp %h", k, out_data, 32'h10 + 32'(k - 3));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic        rdy [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
        logic        ceb [9] = '{0, 0, 0, 1, 1, 0, 1, 1, 1};
        logic        val [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [10:0] ea  [9] = '{'h10, 'h11, 'h12, 'h12, 'h12, 'h13, 'h13, 'h13, 'h13};
        logic [31:0] ed  [9] = '{0, 0, 'h10, 'h11, 'h11, 'h11, 'h12, 'h13, 0};
        issue_cmd(11'h010, 12'd3);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            out_ready = rdy[k-1];
            #1;
            checks++;
            if (sram_CEB !== ceb[k-1] || sram_A !== ea[k-1]) begin
                failures++;
                $display("FAIL bp_sram k=%0d CEB=%b A=%h exp CEB=%b A=%h", k, sram_CEB, sram_A, ceb[k-1], ea[k-1]);
            end
            checks++;
            if ({out_valid, out_last, done} !== {val[k-1], k == 8, k == 9}) begin
                failures++;
                $display("FAIL bp_flags k=%0d got %b exp %b", k, {out_valid, out_last, done}, {val[k-1], k == 8, k == 9});
            end
            if (val[k-1]) begin
                checks++;
                if (out_data !== ed[k-1]) begin
                    failures++;
                    $display("FAIL bp_data k=%0d got %h exp %h", k, out_data, ed[k-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [10:0] ea [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        issue_cmd(11'd2046, 12'd3);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            if (k <= 4) begin
                checks++;
                if (sram_CEB !== 1'b0 || sram_A !== ea[k-1]) begin
                    failures++;
                    $display("FAIL wrap_addr k=%0d CEB=%b A=%0d exp %0d", k, sram_CEB, sram_A, ea[k-1]);
                end
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'(ea[k-3]) || out_last !== (k == 6)) begin
                    failures++;
                    $display("FAIL wrap_data k=%0d v=%b data=%0d last=%b exp %0d", k, out_valid, out_data, out_last, ea[k-3]);
                end
            end
            if (k == 7) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_done got %b exp 1", done);
                end
            end
        end
    endtask

    task automatic test_len0();
        issue_cmd(11'h055, 12'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            checks++;
            if ({sram_CEB, out_valid, out_last, done, cmd_ready} !== {k != 1, k == 3, k == 3, k == 4, k >= 4}
                || sram_A !== 11'h055) begin
                failures++;
                $display("FAIL len0 k=%0d got %b A=%h exp %b A=055", k, {sram_CEB, out_valid, out_last, done, cmd_ready},
                         sram_A, {k != 1, k == 3, k == 3, k == 4, k >= 4});
            end
            if (k == 3) begin
                checks++;
                if (out_data !== 32'h55) begin
                    failures++;
                    $display("FAIL len0_data got %h exp 55", out_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        issue_cmd(11'h100, 12'd7);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            if (k >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'(k - 3)) begin
                    failures++;
                    $display("FAIL rmid_pre k=%0d v=%b data=%h exp %h", k, out_valid, out_data, 32'h100 + 32'(k - 3));
                end
            end
        end
        @(negedge CLK);
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, sram_CEB, cmd_ready, busy, done} !== 5'b01100) begin
            failures++;
            $display("FAIL rmid_reset got %b exp 01100", {out_valid, sram_CEB, cmd_ready, busy, done});
        end
        @(negedge CLK);
        reset = 1'b1;
        issue_cmd(11'h200, 12'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            checks++;
            if ({out_valid, out_last, done} !== {k == 3 || k == 4, k == 4, k == 5}) begin
                failures++;
                $display("FAIL rmid_post k=%0d got %b exp %b", k, {out_valid, out_last, done}, {k == 3 || k == 4, k == 4, k == 5});
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (out_data !== 32'h200 + 32'(k - 3)) begin
                    failures++;
                    $display("FAIL rmid_data k=%0d got %h exp %h", k, out_data, 32'h200 + 32'(k - 3));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        issue_cmd(11'h030, 12'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
        end
        checks++;
        if ({done, cmd_ready} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_done got %b exp 11", {done, cmd_ready});
        end
        cmd_valid = 1'b1;
        cmd_addr  = 11'h040;
        cmd_len   = 12'd0;
        @(negedge CLK);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if ({sram_CEB, busy, done} !== 3'b010 || sram_A !== 11'h040) begin
            failures++;
            $display("FAIL b2b_issue got %b A=%h exp 010 A=040", {sram_CEB, busy, done}, sram_A);
        end
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if ({out_valid, out_last} !== 2'b11 || out_data !== 32'h40) begin
            failures++;
            $display("FAIL b2b_data v/l=%b data=%h exp 11 40", {out_valid, out_last}, out_data);
        end
        repeat (2) @(negedge CLK);
    endtask

`ifdef STREAMER_WRITE_EN
    task automatic test_write();
        logic [31:0] wd [2] = '{32'hA5, 32'h5A};
        issue_cmd(11'h020, 12'd1);
        cmd_write = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            cmd_write = 1'b0;
            in_valid  = 1'b1;
            in_data   = wd[k-1];
            #1;
            checks++;
            if ({in_ready, sram_CEB, sram_WEB, out_valid} !== 4'b1000 || sram_A !== 11'h020 + 11'(k - 1)
                || sram_D !== wd[k-1]) begin
                failures++;
                $display("FAIL write_pins k=%0d got %b A=%h D=%h", k, {in_ready, sram_CEB, sram_WEB, out_valid}, sram_A, sram_D);
            end
        end
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({done, cmd_ready, sram_CEB} !== 3'b111) begin
            failures++;
            $display("FAIL write_done got %b exp 111", {done, cmd_ready, sram_CEB});
        end
        issue_cmd(11'h020, 12'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            if (k >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== wd[k-3]) begin
                    failures++;
                    $display("FAIL write_readback k=%0d got %h exp %h", k, out_data, wd[k-3]);
                end
            end
        end
        repeat (2) @(negedge CLK);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_len0();
        test_reset_mid();
        test_back_to_back();
`ifdef STREAMER_WRITE_EN
        test_write();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
